// File: rtl/sequenciador_rega_if.sv
// sequenciador_rega_if: control and status bundle between the irrigation sequencer and its upstream driver.
interface sequenciador_rega_if;
  logic       Iniciar;
  logic [1:0] REGA_Mode;
  logic       Sensor_cheio;
  logic       Sensor_vazio;
  logic       Parada;
  logic       Reconhecer;
  logic [1:0] Modo_ativo;
  logic       Bomba_Enchimento;
  logic       Nivel_cheio;
  logic       Esvaziar;
  logic       Parada_Rega;
  logic       Limpeza;
  logic       Erro;
  logic [2:0] Estado;
  modport master (
    output Iniciar, REGA_Mode, Sensor_cheio, Sensor_vazio, Parada, Reconhecer,
    input  Modo_ativo, Bomba_Enchimento, Nivel_cheio, Esvaziar, Parada_Rega, Limpeza, Erro, Estado
  );
  modport slave (
    input  Iniciar, REGA_Mode, Sensor_cheio, Sensor_vazio, Parada, Reconhecer,
    output Modo_ativo, Bomba_Enchimento, Nivel_cheio, Esvaziar, Parada_Rega, Limpeza, Erro, Estado
  );
endinterface

// File: rtl/sequenciador_rega.sv
// sequenciador_rega: Moore FSM for one irrigation cycle (fill, full, drain, optional clean) with timeouts and sticky fault.
// Define REGA_LIMPEZA_AUTO_EN to follow each successful drain with the LIMPEZA state.
module sequenciador_rega #(
  parameter int CNT_W          = 8,
  parameter int T_ENCHER_MAX   = 16,
  parameter int T_ESVAZIAR_MAX = 16,
  parameter int T_LIMPEZA      = 4
) (
  input logic                clk,
  input logic                rst_n,
  sequenciador_rega_if.slave bus
);
  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    ENCHENDO   = 3'd1,
    CHEIO      = 3'd2,
    ESVAZIANDO = 3'd3,
    LIMPEZA    = 3'd4,
    FALHA      = 3'd7
  } state_t;
`ifdef REGA_LIMPEZA_AUTO_EN
  localparam state_t POS_DRENO = LIMPEZA;
`else
  localparam state_t POS_DRENO = OCIOSO;
`endif
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       modo_q, modo_d;
  logic             bomba_q, bomba_d, nivel_q, nivel_d, esv_q, esv_d;
  logic             prg_q, prg_d, limp_q, limp_d, erro_q, erro_d;
  logic             contention, fill_to, drain_to, frozen;
  always_comb begin
    contention = bus.Sensor_cheio && bus.Sensor_vazio;
    fill_to    = !bus.Parada && cnt_q == CNT_W'(T_ENCHER_MAX - 1);
    drain_to   = !bus.Parada && cnt_q == CNT_W'(T_ESVAZIAR_MAX - 1);
    frozen     = bus.Parada && (state_q == ENCHENDO || state_q == ESVAZIANDO);
    state_d    = state_q;
    case (state_q)
      OCIOSO:     state_d = !bus.Iniciar ? OCIOSO :
                            bus.REGA_Mode == 2'b11 ? FALHA :
                            bus.REGA_Mode != 2'b00 ? ENCHENDO : OCIOSO;
      ENCHENDO:   state_d = contention ? FALHA : bus.Sensor_cheio ? CHEIO : fill_to ? FALHA : ENCHENDO;
      CHEIO:      state_d = contention ? FALHA : ESVAZIANDO;
      ESVAZIANDO: state_d = contention ? FALHA : bus.Sensor_vazio ? POS_DRENO : drain_to ? FALHA : ESVAZIANDO;
      LIMPEZA:    state_d = cnt_q == CNT_W'(T_LIMPEZA - 1) ? OCIOSO : LIMPEZA;
      FALHA:      state_d = bus.Reconhecer ? OCIOSO : FALHA;
      default:    state_d = OCIOSO;
    endcase
    // every state change restarts the duration count, pause holds it
    cnt_d   = state_d != state_q ? '0 : frozen ? cnt_q : cnt_q + CNT_W'(1);
    modo_d  = state_d == OCIOSO ? 2'b00 :
              (state_q == OCIOSO && state_d == ENCHENDO) ? bus.REGA_Mode : modo_q;
    bomba_d = state_d == ENCHENDO && !bus.Parada;
    nivel_d = state_d == CHEIO;
    esv_d   = state_d == ESVAZIANDO;
    prg_d   = state_d == ESVAZIANDO && bus.Parada;
    limp_d  = state_d == LIMPEZA;
    erro_d  = state_d == FALHA;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCIOSO;
      cnt_q   <= '0;
      modo_q  <= 2'b00;
      bomba_q <= 1'b0;
      nivel_q <= 1'b0;
      esv_q   <= 1'b0;
      prg_q   <= 1'b0;
      limp_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      modo_q  <= modo_d;
      bomba_q <= bomba_d;
      nivel_q <= nivel_d;
      esv_q   <= esv_d;
      prg_q   <= prg_d;
      limp_q  <= limp_d;
      erro_q  <= erro_d;
    end
  end
  assign bus.Estado           = state_q;
  assign bus.Modo_ativo       = modo_q;
  assign bus.Bomba_Enchimento = bomba_q;
  assign bus.Nivel_cheio      = nivel_q;
  assign bus.Esvaziar         = esv_q;
  assign bus.Parada_Rega      = prg_q;
  assign bus.Limpeza          = limp_q;
  assign bus.Erro             = erro_q;
endmodule

// File: tb/tb_sequenciador_rega.sv
// tb_sequenciador_rega: directed boundary cases plus random stimulus, checked by a scoreboard against a reference model.
`timescale 1ns/1ps
module tb_sequenciador_rega;
  localparam int TE = 16, TV = 16, TL = 4;
  localparam int S_IDLE = 0, S_FILL = 1, S_FULL = 2, S_DRAIN = 3, S_CLEAN = 4, S_FAULT = 7;
  logic clk = 1'b0, rst_n = 1'b0, rst_want = 1'b0;
  int n_vec = 0, n_bad = 0;
  logic [10:0] sb[$];
  int m_st = S_IDLE, m_cnt = 0;
  logic [1:0] m_mode = 2'b00;
  sequenciador_rega_if bus();
  sequenciador_rega dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic ck(string nm, int g, int e);
    n_vec++;
    if (g != e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, g, e, $time);
    end
  endtask
  function automatic int got_vec();
    return int'({bus.Estado, bus.Modo_ativo, bus.Bomba_Enchimento, bus.Nivel_cheio,
                 bus.Esvaziar, bus.Parada_Rega, bus.Limpeza, bus.Erro});
  endfunction
  always @(negedge clk) begin
    if (sb.size() != 0) ck("scoreboard", got_vec(), int'(sb.pop_front()));
  end
  function automatic int model_next(logic ini, logic [1:0] md, logic sc, logic sv, logic par, logic rec);
    int after_drain;
`ifdef REGA_LIMPEZA_AUTO_EN
    after_drain = S_CLEAN;
`else
    after_drain = S_IDLE;
`endif
    if (sc && sv && (m_st == S_FILL || m_st == S_FULL || m_st == S_DRAIN)) return S_FAULT;
    case (m_st)
      S_IDLE:  return !ini ? S_IDLE : md == 2'b11 ? S_FAULT : md == 2'b00 ? S_IDLE : S_FILL;
      S_FILL:  return sc ? S_FULL : (!par && m_cnt == TE - 1) ? S_FAULT : S_FILL;
      S_FULL:  return S_DRAIN;
      S_DRAIN: return sv ? after_drain : (!par && m_cnt == TV - 1) ? S_FAULT : S_DRAIN;
      S_CLEAN: return m_cnt == TL - 1 ? S_IDLE : S_CLEAN;
      default: return rec ? S_IDLE : S_FAULT;
    endcase
  endfunction
  task automatic cyc(logic ini, logic [1:0] md, logic sc, logic sv, logic par, logic rec);
    int nst;
    @(negedge clk);
    #1;
    rst_n = rst_want;
    bus.Iniciar = ini; bus.REGA_Mode = md; bus.Sensor_cheio = sc;
    bus.Sensor_vazio = sv; bus.Parada = par; bus.Reconhecer = rec;
    if (!rst_n) begin
      m_st = S_IDLE; m_cnt = 0; m_mode = 2'b00;
    end else begin
      nst = model_next(ini, md, sc, sv, par, rec);
      if (m_st == S_IDLE && nst == S_FILL) m_mode = md;
      if (nst == S_IDLE) m_mode = 2'b00;
      if (nst != m_st) m_cnt = 0;
      else if (!(par && (m_st == S_FILL || m_st == S_DRAIN))) m_cnt++;
      m_st = nst;
    end
    sb.push_back({3'(m_st), m_mode, m_st == S_FILL && !par, m_st == S_FULL, m_st == S_DRAIN,
                  m_st == S_DRAIN && par, m_st == S_CLEAN, m_st == S_FAULT});
  endtask
  task automatic post();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int n);
    repeat (n) cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic ack();
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  initial begin
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    post();
    ck("reset_estado", int'(bus.Estado), 0);
    ck("reset_erro", int'(bus.Erro), 0);
    rst_want = 1'b1;
    // normal cycle in mode 01; REGA_Mode flips to 10 mid-fill and must be ignored
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    post();
    ck("start_estado", int'(bus.Estado), 1);
    ck("start_bomba", int'(bus.Bomba_Enchimento), 1);
    repeat (4) cyc(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    post();
    ck("cheio_estado", int'(bus.Estado), 2);
    ck("cheio_nivel", int'(bus.Nivel_cheio), 1);
    ck("latched_mode", int'(bus.Modo_ativo), 1);
    idle(1);
    post();
    ck("drain_estado", int'(bus.Estado), 3);
    ck("drain_esvaziar", int'(bus.Esvaziar), 1);
    idle(10);
    repeat (20) cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    post();
    ck("pause_no_timeout", int'(bus.Estado), 3);
    ck("pause_parada_rega", int'(bus.Parada_Rega), 1);
    idle(5);
    post();
    ck("pause_release_5", int'(bus.Estado), 3);
    idle(1);
    post();
    ck("drain_timeout", int'(bus.Estado), 7);
    ck("drain_timeout_esv", int'(bus.Esvaziar), 0);
    ck("fault_keeps_mode", int'(bus.Modo_ativo), 1);
    ack();
    post();
    ck("ack_idle", int'(bus.Estado), 0);
    ck("ack_mode_clear", int'(bus.Modo_ativo), 0);
    // fill timeout in mode 10
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(15);
    post();
    ck("fill_cnt15", int'(bus.Estado), 1);
    idle(1);
    post();
    ck("fill_timeout", int'(bus.Estado), 7);
    idle(3);
    post();
    ck("erro_sticky", int'(bus.Erro), 1);
    ack();
    post();
    ck("fill_ack", int'(bus.Estado), 0);
    cyc(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    post();
    ck("invalid_mode", int'(bus.Estado), 7);
    ck("invalid_mode_modo", int'(bus.Modo_ativo), 0);
    ack();
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    post();
    ck("contention", int'(bus.Estado), 7);
    ack();
    // sensor on the timeout cycle wins
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(15);
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    post();
    ck("sensor_beats_timeout", int'(bus.Estado), 2);
    idle(1);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    post();
`ifdef REGA_LIMPEZA_AUTO_EN
    ck("clean_entry", int'(bus.Estado), 4);
    ck("clean_out", int'(bus.Limpeza), 1);
    idle(3);
    post();
    ck("clean_last", int'(bus.Estado), 4);
    idle(1);
    post();
    ck("clean_done", int'(bus.Estado), 0);
`else
    ck("drain_done", int'(bus.Estado), 0);
    ck("no_clean", int'(bus.Limpeza), 0);
`endif
    // asynchronous reset in the middle of the drain
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    post();
    #2;
    rst_want = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    m_st = S_IDLE; m_cnt = 0; m_mode = 2'b00;
    #1;
    ck("async_rst_estado", int'(bus.Estado), 0);
    ck("async_rst_esv", int'(bus.Esvaziar), 0);
    ck("async_rst_modo", int'(bus.Modo_ativo), 0);
    idle(1);
    rst_want = 1'b1;
    repeat (3000) cyc($urandom_range(3) == 0, 2'($urandom), $urandom_range(7) == 0,
                      $urandom_range(7) == 0, $urandom_range(5) == 0, $urandom_range(7) == 0);
    repeat (3000) cyc($urandom_range(1) == 0, 2'($urandom_range(1, 2)), $urandom_range(24) == 0,
                      $urandom_range(24) == 0, $urandom_range(4) == 0, $urandom_range(9) == 0);
    idle(1);
    repeat (2) @(negedge clk);
    #1;
    ck("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
